// File: rtl/perceptron_train_ctrl.sv
// rtl/perceptron_train_ctrl.sv - perceptron training sequencer: train/eval epochs, lr decay, final test pass
module perceptron_train_ctrl #(
    parameter int NUM_TRAIN    = 4,
    parameter int NUM_TEST     = 4,
    parameter int OUTPUTS      = 1,
    parameter int MAX_EPOCHS   = 10,
    parameter int DECAY_EPOCHS = 0,
    parameter int SFP_W        = 16,
    parameter int IDX_W        = $clog2(NUM_TRAIN + NUM_TEST),
    parameter int EP_W         = $clog2(MAX_EPOCHS + 1),
    parameter int TR_W         = $clog2(NUM_TRAIN + 1),
    parameter int TE_W         = $clog2(NUM_TEST + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [SFP_W-1:0]                lr_init,
    input  logic [OUTPUTS-1:0][SFP_W-1:0]   prediction,
    input  logic [OUTPUTS-1:0][SFP_W-1:0]   expected,
    output logic [IDX_W-1:0]                example,
    output logic                            training,
    output logic [SFP_W-1:0]                learning_rate,
    output logic                            busy,
    output logic                            done,
    output logic                            converged,
    output logic [EP_W-1:0]                 epochs_run,
    output logic [TR_W-1:0]                 train_correct,
    output logic [TE_W-1:0]                 test_correct
);
    typedef enum logic [2:0] {IDLE, TRAIN, EVAL, TEST, DONE} state_t;

    localparam int DC_W = (DECAY_EPOCHS > 1) ? $clog2(DECAY_EPOCHS) : 1;
    localparam logic [IDX_W-1:0] LAST_TRAIN = IDX_W'(NUM_TRAIN - 1);
    localparam logic [IDX_W-1:0] FIRST_TEST = IDX_W'(NUM_TRAIN);
    localparam logic [IDX_W-1:0] LAST_TEST  = IDX_W'(NUM_TRAIN + NUM_TEST - 1);
    localparam logic [DC_W-1:0]  DC_LAST    = DC_W'(DECAY_EPOCHS - 1);

    state_t           state;
    logic [TR_W-1:0]  score;
    logic [DC_W-1:0]  decay_cnt;
    logic             correct;
    logic [TR_W-1:0]  score_next;
    logic [EP_W-1:0]  epochs_next;
    logic [SFP_W-1:0] lr_half;
    logic [SFP_W-1:0] lr_decayed;

    always_comb begin
        correct = 1'b1;
        for (int i = 0; i < OUTPUTS; i++) begin
            if (prediction[i] != expected[i]) correct = 1'b0;
        end
    end

    assign score_next  = score + TR_W'(correct);
    assign epochs_next = epochs_run + EP_W'(1);
    // Arithmetic halving, never letting a nonzero rate collapse to zero.
    assign lr_half     = {learning_rate[SFP_W-1], learning_rate[SFP_W-1:1]};
    assign lr_decayed  = (learning_rate != '0 && lr_half == '0) ? SFP_W'(1) : lr_half;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            example       <= '0;
            training      <= 1'b0;
            learning_rate <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            converged     <= 1'b0;
            epochs_run    <= '0;
            train_correct <= '0;
            test_correct  <= '0;
            score         <= '0;
            decay_cnt     <= '0;
        end else if (abort) begin
            state         <= IDLE;
            example       <= '0;
            training      <= 1'b0;
            learning_rate <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            converged     <= 1'b0;
            epochs_run    <= '0;
            train_correct <= '0;
            test_correct  <= '0;
            score         <= '0;
            decay_cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= TRAIN;
                        example       <= '0;
                        training      <= 1'b1;
                        learning_rate <= lr_init;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        converged     <= 1'b0;
                        epochs_run    <= '0;
                        train_correct <= '0;
                        test_correct  <= '0;
                        score         <= '0;
                        decay_cnt     <= '0;
                    end
                end
                TRAIN: begin
                    if (example == LAST_TRAIN) begin
                        state    <= EVAL;
                        example  <= '0;
                        training <= 1'b0;
                        score    <= '0;
                    end else begin
                        example <= example + IDX_W'(1);
                    end
                end
                EVAL: begin
                    if (example == LAST_TRAIN) begin
                        train_correct <= score_next;
                        epochs_run    <= epochs_next;
                        score         <= '0;
                        if (score_next == TR_W'(NUM_TRAIN)) begin
                            converged <= 1'b1;
                            state     <= TEST;
                            example   <= FIRST_TEST;
                        end else if (epochs_next == EP_W'(MAX_EPOCHS)) begin
                            state   <= TEST;
                            example <= FIRST_TEST;
                        end else begin
                            state    <= TRAIN;
                            example  <= '0;
                            training <= 1'b1;
                            if (DECAY_EPOCHS > 0) begin
                                if (decay_cnt == DC_LAST) begin
                                    decay_cnt     <= '0;
                                    learning_rate <= lr_decayed;
                                end else begin
                                    decay_cnt <= decay_cnt + DC_W'(1);
                                end
                            end
                        end
                    end else begin
                        score   <= score_next;
                        example <= example + IDX_W'(1);
                    end
                end
                TEST: begin
                    test_correct <= test_correct + TE_W'(correct);
                    if (example == LAST_TEST) begin
                        state   <= DONE;
                        example <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        example <= example + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// tb/tb_perceptron_train_ctrl.sv - directed bench for perceptron_train_ctrl with a stub predictor
module tb_perceptron_train_ctrl;
    localparam int SFP_W = 16;
    localparam logic [SFP_W-1:0] ONE = 16'd256;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [SFP_W-1:0]      lr_init = '0;
    logic [1:0][SFP_W-1:0] prediction;
    logic [1:0][SFP_W-1:0] expected;
    logic [2:0]            example;
    logic                  training;
    logic [SFP_W-1:0]      learning_rate;
    logic                  busy;
    logic                  done;
    logic                  converged;
    logic [3:0]            epochs_run;
    logic [2:0]            train_correct;
    logic [2:0]            test_correct;

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;
    int cycles;
    logic [SFP_W-1:0] lr_seen [10];
    logic [2:0]       ex_at9;
    logic             tr_at9;

    perceptron_train_ctrl #(
        .NUM_TRAIN(4), .NUM_TEST(4), .OUTPUTS(2), .MAX_EPOCHS(10),
        .DECAY_EPOCHS(2), .SFP_W(SFP_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .lr_init(lr_init),
        .prediction(prediction), .expected(expected), .example(example),
        .training(training), .learning_rate(learning_rate), .busy(busy),
        .done(done), .converged(converged), .epochs_run(epochs_run),
        .train_correct(train_correct), .test_correct(test_correct)
    );

    always #5 clk = ~clk;

    // Stub predictor: 0 = always right, 1 = always wrong, 2 = channel 1 wrong on examples 3 and 6.
    always_comb begin
        expected[0]   = {13'd0, example} + 16'd10;
        expected[1]   = {13'd0, example} + 16'd20;
        prediction    = expected;
        if (mode == 1) prediction[0] = expected[0] + 16'd1;
        if (mode == 2 && (example == 3'd3 || example == 3'd6)) prediction[1] = expected[1] + 16'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Starts a run, counts edges (start edge included) until done, records lr at epoch starts.
    task automatic run(input int m, input logic [SFP_W-1:0] lr);
        mode    = m;
        lr_init = lr;
        start   = 1'b1;
        cycles  = 0;
        for (int i = 0; i < 10; i++) lr_seen[i] = 'x;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            start  = (c == 20);
            cycles = c;
            if ((c - 1) % 8 == 0 && (c - 1) / 8 < 10) lr_seen[(c - 1) / 8] = learning_rate;
            if (c == 9) begin
                ex_at9 = example;
                tr_at9 = training;
            end
            if (done) break;
        end
        start = 1'b0;
        check("done_within_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_example"}, {29'd0, example}, 32'd0);
        check({tag, "_training"}, {31'd0, training}, 32'd0);
        check({tag, "_lr"}, {16'd0, learning_rate}, 32'd0);
        check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_epochs"}, {28'd0, epochs_run}, 32'd0);
        check({tag, "_scores"}, {26'd0, train_correct, test_correct}, 32'd0);
    endtask

    initial begin
        #12;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Always correct: converges in epoch 1, TEST entered 9 cycles after start.
        run(0, ONE);
        check("conv_cycles", cycles, 32'd13);
        check("conv_ex_at9", {29'd0, ex_at9}, 32'd4);
        check("conv_train_at9", {31'd0, tr_at9}, 32'd0);
        check("conv_flag", {31'd0, converged}, 32'd1);
        check("conv_epochs", {28'd0, epochs_run}, 32'd1);
        check("conv_train_correct", {29'd0, train_correct}, 32'd4);
        check("conv_test_correct", {29'd0, test_correct}, 32'd4);
        check("conv_lr", {16'd0, learning_rate}, {16'd0, ONE});
        check("conv_example_done", {29'd0, example}, 32'd0);

        // Never correct: full 10 epochs, decay every 2 epochs, stray start ignored.
        run(1, ONE);
        check("nc_cycles", cycles, 32'd85);
        check("nc_conv", {31'd0, converged}, 32'd0);
        check("nc_epochs", {28'd0, epochs_run}, 32'd10);
        check("nc_scores", {26'd0, train_correct, test_correct}, 32'd0);
        check("nc_lr_ep1", {16'd0, lr_seen[0]}, 32'd256);
        check("nc_lr_ep2", {16'd0, lr_seen[1]}, 32'd256);
        check("nc_lr_ep3", {16'd0, lr_seen[2]}, 32'd128);
        check("nc_lr_ep5", {16'd0, lr_seen[4]}, 32'd64);
        check("nc_lr_ep10", {16'd0, lr_seen[9]}, 32'd16);
        check("nc_lr_final", {16'd0, learning_rate}, 32'd16);

        // Two channels, one wrong on examples 3 and 6; small lr exercises the 1-LSB floor.
        run(2, 16'd3);
        check("ch_cycles", cycles, 32'd85);
        check("ch_train_correct", {29'd0, train_correct}, 32'd3);
        check("ch_test_correct", {29'd0, test_correct}, 32'd3);
        check("ch_conv", {31'd0, converged}, 32'd0);
        check("floor_ep3", {16'd0, lr_seen[2]}, 32'd1);
        check("floor_ep5", {16'd0, lr_seen[4]}, 32'd1);
        check("floor_final", {16'd0, learning_rate}, 32'd1);

        // Zero learning rate never becomes nonzero.
        run(1, 16'd0);
        check("zero_lr_final", {16'd0, learning_rate}, 32'd0);

        // Abort in first EVAL cycle, then start on the following cycle.
        mode    = 0;
        lr_init = ONE;
        start   = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("pre_abort_in_eval", {28'd0, training, example}, 32'd0);
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_reset_vals("abort");
        run(0, ONE);
        check("post_abort_cycles", cycles, 32'd13);
        check("post_abort_test", {29'd0, test_correct}, 32'd4);

        // Async reset pulse mid-TRAIN.
        mode    = 1;
        lr_init = ONE;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_training", {31'd0, training}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        run(0, ONE);
        check("post_rst_cycles", cycles, 32'd13);
        check("post_rst_conv", {31'd0, converged}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
